// File: rtl/frame_packer.sv
// MP3 frame-prefix serialiser: header, optional CRC-16, 256-bit side info.
// Byte stream on axiod/axiov/axior; busy/done report frame progress.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  capture all field inputs (IDLE only)
//   prot .. emphasis       header fields (prot=0 adds the CRC)
//   main_data_begin ..     side-info fields, [gr][ch] indexed
//   axiod, axiov, axior    output byte, valid, sink ready
//   busy, done             not idle; one-cycle end-of-frame pulse
module frame_packer #(
  parameter logic [15:0] CRC_POLY = 16'h8005,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       prot,
  input  logic [3:0]                 bitrate_index,
  input  logic [1:0]                 sampling_freq,
  input  logic                       padding,
  input  logic [1:0]                 mode,
  input  logic [1:0]                 mode_ext,
  input  logic [1:0]                 emphasis,
  input  logic [8:0]                 main_data_begin,
  input  logic [2:0]                 private_bits,
  input  logic [1:0][3:0]            scfsi,
  input  logic [1:0][1:0][11:0]      part2_3_length,
  input  logic [1:0][1:0][8:0]       big_values,
  input  logic [1:0][1:0][7:0]       global_gain,
  input  logic [1:0][1:0][3:0]       scalefac_compress,
  input  logic [1:0][1:0]            window_switching_flag,
  input  logic [1:0][1:0][1:0]       block_type,
  input  logic [1:0][1:0]            mixed_block_flag,
  input  logic [1:0][1:0][2:0][4:0]  table_select,
  input  logic [1:0][1:0][2:0][2:0]  subblock_gain,
  input  logic [1:0][1:0][3:0]       region0_count,
  input  logic [1:0][1:0][3:0]       region1_count,
  input  logic [1:0][1:0]            preflag,
  input  logic [1:0][1:0]            scalefac_scale,
  input  logic [1:0][1:0]            count1table_select,
  output logic [7:0]                 axiod,
  output logic                       axiov,
  input  logic                       axior,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    IDLE, CRC, SEND, FIN
  } state_t;

  state_t state, state_d;

  logic [31:0]  hdr_q, hdr_in;
  logic [255:0] si_q, si_in;
  logic [15:0]  crc_q, crc_d, crc_nx;
  logic [8:0]   cnt, cnt_d, cnt_n;
  logic [8:0]   base, last;
  logic [7:0]   axiod_d;
  logic         axiov_d, done_d, load;
  logic         crc_bit;
  logic [271:0] crc_vec;
  logic [303:0] frame;
  logic [1:0][1:0][58:0] grch;
  logic         unused_bits;

  // Leading 13 ones = 11-bit sync plus the MPEG-1 ID pair.
  assign hdr_in = {11'h7FF, 2'b11, 2'b01, prot,
                   bitrate_index, sampling_freq,
                   padding, 1'b0, mode, mode_ext,
                   2'b00, emphasis};

  always_comb begin
    grch = '0;
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < 2; c++) begin
        grch[g][c] = {
          part2_3_length[g][c],
          big_values[g][c],
          global_gain[g][c],
          scalefac_compress[g][c],
          window_switching_flag[g][c],
          window_switching_flag[g][c] ?
            {block_type[g][c],
             mixed_block_flag[g][c],
             table_select[g][c][0],
             table_select[g][c][1],
             subblock_gain[g][c][0],
             subblock_gain[g][c][1],
             subblock_gain[g][c][2]} :
            {table_select[g][c][0],
             table_select[g][c][1],
             table_select[g][c][2],
             region0_count[g][c],
             region1_count[g][c][2:0]},
          preflag[g][c],
          scalefac_scale[g][c],
          count1table_select[g][c]};
      end
    end
  end

  assign si_in = {main_data_begin, private_bits,
                  scfsi[0], scfsi[1],
                  grch[0][0], grch[0][1],
                  grch[1][0], grch[1][1]};

  assign unused_bits = ^{region1_count[0][0][3],
                         region1_count[0][1][3],
                         region1_count[1][0][3],
                         region1_count[1][1][3],
                         cnt_n[8:6]};

  // CRC covers header[15:0] then side info, MSB first.
  assign crc_vec = {hdr_q[15:0], si_q};
  assign crc_bit = crc_vec[9'd271 - cnt];
  assign crc_nx  = {crc_q[14:0], 1'b0}
                 ^ ((crc_q[15] ^ crc_bit) ? CRC_POLY : 16'h0);

  // Whole frame as one vector; byte k sits at bit 303-8k.
  assign frame = hdr_q[16] ? {hdr_q, si_q, 16'h0}
                           : {hdr_q, crc_q, si_q};
  assign cnt_n = cnt + 9'd1;
  assign base  = 9'd303 - {cnt_n[5:0], 3'b000};
  assign last  = hdr_q[16] ? 9'd35 : 9'd37;

  always_comb begin
    state_d = state;
    load    = 1'b0;
    crc_d   = crc_q;
    cnt_d   = cnt;
    axiov_d = axiov;
    axiod_d = axiod;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        crc_d = CRC_INIT;
        if (start) begin
          load  = 1'b1;
          cnt_d = '0;
          if (prot) begin
            state_d = SEND;
            axiov_d = 1'b1;
            axiod_d = hdr_in[31:24];
          end else begin
            state_d = CRC;
          end
        end
      end
      CRC: begin
        crc_d = crc_nx;
        cnt_d = cnt_n;
        if (cnt == 9'd271) begin
          state_d = SEND;
          cnt_d   = '0;
          axiov_d = 1'b1;
          axiod_d = hdr_q[31:24];
        end
      end
      SEND: begin
        if (axiov && axior) begin
          if (cnt == last) begin
            state_d = FIN;
            axiov_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_n;
            axiod_d = frame[base -: 8];
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q <= '0;
      si_q  <= '0;
      crc_q <= CRC_INIT;
      cnt   <= '0;
      axiov <= 1'b0;
      axiod <= '0;
      done  <= 1'b0;
    end else begin
      if (load) begin
        hdr_q <= hdr_in;
        si_q  <= si_in;
      end
      crc_q <= crc_d;
      cnt   <= cnt_d;
      axiov <= axiov_d;
      axiod <= axiod_d;
      done  <= done_d;
    end
  end

  assign busy = (state != IDLE);

endmodule
